// File: rtl/distortion_ctrl.sv
// distortion_ctrl: debounced toggle/up/down buttons drive an OFF/RAMP/ON/FADE_OUT gain ramp; outputs enable, gain_factor, target_gain, update, busy.
module distortion_ctrl #(
  parameter int GAIN_MAX        = 11,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int RAMP_SAMPLES    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic        btn_toggle,
  input  logic        btn_up,
  input  logic        btn_down,
  output logic        enable,
  output logic [11:0] gain_factor,
  output logic [11:0] target_gain,
  output logic        update,
  output logic        busy
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(RAMP_SAMPLES + 1);
  localparam logic [11:0] GMAX = 12'(GAIN_MAX);
  typedef enum logic [1:0] {OFF, RAMP, ON, FADE_OUT} state_t;
  logic [2:0] btn, press;
  assign btn = {btn_down, btn_up, btn_toggle};
  for (genvar i = 0; i < 3; i++) begin : g_deb
    logic s1_q, s2_q, lvl_q, diff, acc;
    logic [DW-1:0] cnt_q;
    assign diff     = s2_q != lvl_q;
    assign acc      = diff && cnt_q == DW'(DEBOUNCE_CYCLES - 1);
    assign press[i] = acc & s2_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        s1_q  <= 1'b0;
        s2_q  <= 1'b0;
        lvl_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        s1_q  <= btn[i];
        s2_q  <= s1_q;
        cnt_q <= (!diff || acc) ? '0 : cnt_q + 1'b1;
        if (acc) lvl_q <= s2_q;
      end
    end
  end
  logic tog, up, dn, step;
  assign tog = press[0];
  assign up  = press[1] & ~press[2];
  assign dn  = press[2] & ~press[1];
  state_t state_q, state_d;
  logic en_q, en_d, upd_q, upd_d, busy_q, busy_d;
  logic [11:0] gain_q, gain_d, tgt_q, tgt_d;
  logic [RW-1:0] rcnt_q, rcnt_d, rcnt_inc;
  assign step     = sample_valid && rcnt_q == RW'(RAMP_SAMPLES - 1);
  assign rcnt_inc = sample_valid ? rcnt_q + 1'b1 : rcnt_q;
  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    gain_d  = gain_q;
    rcnt_d  = rcnt_q;
    upd_d   = 1'b0;
    tgt_d   = up ? ((tgt_q == GMAX) ? tgt_q : tgt_q + 12'd1)
            : dn ? ((tgt_q == 12'd0) ? tgt_q : tgt_q - 12'd1) : tgt_q;
    case (state_q)
      OFF: if (tog) state_d = RAMP;
      RAMP:
        if (tog) state_d = FADE_OUT;
        else if (!en_q) begin
          en_d  = sample_valid;
          upd_d = sample_valid;
        end else if (gain_q == tgt_q) state_d = ON;
        else if (step) begin
          gain_d = gain_q < tgt_q ? gain_q + 12'd1 : gain_q - 12'd1;
          upd_d  = 1'b1;
          rcnt_d = '0;
        end else rcnt_d = rcnt_inc;
      ON: state_d = tog ? FADE_OUT : (gain_q != tgt_q) ? RAMP : ON;
      default:
        if (tog) state_d = RAMP;
        else if (gain_q == 12'd0) begin
          if (sample_valid) begin
            en_d    = 1'b0;
            upd_d   = 1'b1;
            state_d = OFF;
          end
        end else if (step) begin
          gain_d = gain_q - 12'd1;
          upd_d  = 1'b1;
          rcnt_d = '0;
        end else rcnt_d = rcnt_inc;
    endcase
    if (state_d != state_q) rcnt_d = '0;
    busy_d = state_d == RAMP || state_d == FADE_OUT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= OFF;
      en_q    <= 1'b0;
      gain_q  <= '0;
      tgt_q   <= 12'(GAIN_MAX / 2);
      rcnt_q  <= '0;
      upd_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      gain_q  <= gain_d;
      tgt_q   <= tgt_d;
      rcnt_q  <= rcnt_d;
      upd_q   <= upd_d;
      busy_q  <= busy_d;
    end
  end
  assign enable      = en_q;
  assign gain_factor = gain_q;
  assign target_gain = tgt_q;
  assign update      = upd_q;
  assign busy        = busy_q;
endmodule

// File: doc/distortion_ctrl.md
DISTORTION_CTRL -- requirements
Module: distortion_ctrl

Interface
REQ-001 SHALL have parameter GAIN_MAX, default 11, meaning the maximum gain_factor value (shift amount).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning the clk cycles a synchronized button must stay stable before it is accepted.
REQ-003 SHALL have parameter RAMP_SAMPLES, default 64, meaning the sample strobes per 1-step gain change during a ramp.
REQ-004 SHALL have one clock and a synchronous active-high reset: clk  input  1  system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 sample_valid  input  1  one-clk strobe marking each new audio sample.
REQ-007 btn_toggle, btn_up, btn_down  input  1 each  raw asynchronous buttons, active-high.
REQ-008 enable  output  1  distortion path enabled.
REQ-009 gain_factor  output  12  applied gain shift, 0..GAIN_MAX.
REQ-010 target_gain  output  12  user-selected gain, 0..GAIN_MAX.
REQ-011 update  output  1  one-clk pulse when enable or gain_factor changes.
REQ-012 busy  output  1  high in RAMP or FADE_OUT.

Function
REQ-013 Each button SHALL pass a 2-flop synchronizer, then a debounce counter that loads the new level only after DEBOUNCE_CYCLES consecutive equal samples; the counter clears on any mismatch.
REQ-014 A debounced 0->1 edge SHALL produce exactly one press pulse; holding a button produces no repeats.
REQ-015 Up press SHALL increment target_gain, saturating at GAIN_MAX; down press SHALL decrement it, saturating at 0.
REQ-016 Up and down presses in the same cycle SHALL both be ignored.
REQ-017 The FSM SHALL have states OFF, RAMP, ON and FADE_OUT.
REQ-018 OFF: enable=0, gain_factor=0; on a toggle press, go to RAMP and set enable=1 at the next sample_valid.
REQ-019 RAMP: after every RAMP_SAMPLES sample_valid strobes, gain_factor SHALL move 1 toward target_gain; when they are equal, go to ON.
REQ-020 ON: if target_gain differs from gain_factor, go to RAMP. A toggle press SHALL go to FADE_OUT.
REQ-021 FADE_OUT: gain_factor SHALL step down by 1 every RAMP_SAMPLES strobes. At 0, enable SHALL clear at the next sample_valid and the FSM goes to OFF.
REQ-022 A toggle press in RAMP SHALL go to FADE_OUT from the current gain_factor; a toggle press in FADE_OUT SHALL go to RAMP toward target_gain.
REQ-023 All enable and gain_factor changes SHALL occur only on a cycle with sample_valid=1; update pulses on that same cycle.
REQ-024 The ramp sample counter SHALL reset to 0 on every state change and on every gain step.
REQ-025 A toggle press together with an up or down press in the same cycle SHALL apply both: the target changes and the state transitions.
REQ-026 Without sample_valid strobes, presses SHALL still update target_gain and the state, but outputs do not change.
REQ-027 A ramp of N steps SHALL complete in N*RAMP_SAMPLES strobes.
REQ-028 target_gain SHALL be applied directly, with no extra pipeline stage.
REQ-029 gain_factor[11:4] SHALL always be 0.

Reset
REQ-030 While reset is sampled high, the module SHALL set state=OFF, enable=0, gain_factor=0, target_gain=GAIN_MAX/2 (integer), update=0 and busy=0, and clear all counters and synchronizers.
REQ-031 Reset asserted mid-ramp SHALL abort the ramp with no update pulse; operation restarts from OFF on the first clk with reset low.

Verification
REQ-032 Reset, then a toggle press with DEBOUNCE_CYCLES=4 and RAMP_SAMPLES=2 -> enable=1 at the next strobe, gain_factor 0->5 in 10 strobes, 6 update pulses, then ON with busy=0.
REQ-033 Bounce btn_up high for 3 cycles (DEBOUNCE_CYCLES=4) -> target_gain unchanged; hold it for 4 or more cycles -> +1 exactly once.
REQ-034 Press up 10 times from target 5 -> target_gain saturates at 11; press down 15 times -> saturates at 0.
REQ-035 In ON at gain 5, toggle press -> FADE_OUT, gain steps 5->0 over 10 strobes, enable=0 one strobe later, state OFF.
REQ-036 During RAMP at gain 3, toggle press -> FADE_OUT from 3; a second toggle at gain 2 -> RAMP back toward target_gain.
REQ-037 Assert reset while FADE_OUT is at gain 4 -> next cycle enable=0, gain_factor=0, target_gain=5, busy=0.
